// File: rtl/axi_full_reg_bridge.sv
// rtl/axi_full_reg_bridge.sv - AXI4 slave that splits bursts into single-beat register bus accesses
module axi_full_reg_bridge #(
    parameter int AXI_WIDTH_ID   = 4,
    parameter int AXI_WIDTH_ADDR = 32,
    parameter int AXI_WIDTH_DATA = 32,
    parameter int REG_ADDR_BITS  = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXI_WIDTH_ID-1:0]     s_axi_awid,
    input  logic [AXI_WIDTH_ADDR-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic                        s_axi_awlock,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic [3:0]                  s_axi_awcache,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_WIDTH_DATA-1:0]   s_axi_wdata,
    input  logic [AXI_WIDTH_DATA/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_WIDTH_ID-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_WIDTH_ID-1:0]     s_axi_arid,
    input  logic [AXI_WIDTH_ADDR-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic                        s_axi_arlock,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic [3:0]                  s_axi_arcache,
    input  logic [2:0]                  s_axi_arprot,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_WIDTH_ID-1:0]     s_axi_rid,
    output logic [AXI_WIDTH_DATA-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [REG_ADDR_BITS-1:0]    reg_addr,
    output logic                        reg_wen,
    output logic [AXI_WIDTH_DATA-1:0]   reg_wdata,
    output logic [AXI_WIDTH_DATA/8-1:0] reg_wstrb,
    output logic                        reg_ren,
    input  logic [AXI_WIDTH_DATA-1:0]   reg_rdata
);

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WRESP,
        S_RREQ,
        S_RDATA
    } state_t;

    state_t                      state;
    logic [AXI_WIDTH_ID-1:0]     id_q;
    logic [REG_ADDR_BITS-1:0]    addr_q;
    logic [7:0]                  len_q;
    logic [7:0]                  cnt_q;
    logic [1:0]                  burst_q;
    logic                        err_q;
    logic                        last_rd_q;
    logic                        rfirst_q;
    logic [AXI_WIDTH_DATA-1:0]   rdata_q;

    logic                        aw_grant;
    logic                        ar_grant;
    logic                        beat_last;
    logic                        wlast_bad;
    logic [REG_ADDR_BITS-1:0]    next_addr;
    logic [AXI_WIDTH_DATA-1:0]   rd_now;
    logic                        unused_inputs;

    // Ties go to whichever channel lost the previous arbitration.
    assign aw_grant  = aresetn && (state == S_IDLE) && s_axi_awvalid &&
                       (!s_axi_arvalid || last_rd_q);
    assign ar_grant  = aresetn && (state == S_IDLE) && s_axi_arvalid && !aw_grant;
    assign beat_last = (cnt_q == len_q);
    assign wlast_bad = (s_axi_wlast != beat_last);
    assign next_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + REG_ADDR_BITS'(4);
    assign rd_now    = err_q ? '0 : reg_rdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            last_rd_q <= 1'b1;
            rfirst_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (aw_grant) begin
                        id_q      <= s_axi_awid;
                        addr_q    <= {s_axi_awaddr[REG_ADDR_BITS-1:2], 2'b00};
                        len_q     <= s_axi_awlen;
                        burst_q   <= s_axi_awburst;
                        cnt_q     <= '0;
                        err_q     <= (s_axi_awsize != 3'd2) || s_axi_awburst[1];
                        last_rd_q <= 1'b0;
                        state     <= S_WDATA;
                    end else if (ar_grant) begin
                        id_q      <= s_axi_arid;
                        addr_q    <= {s_axi_araddr[REG_ADDR_BITS-1:2], 2'b00};
                        len_q     <= s_axi_arlen;
                        burst_q   <= s_axi_arburst;
                        cnt_q     <= '0;
                        err_q     <= (s_axi_arsize != 3'd2) || s_axi_arburst[1];
                        last_rd_q <= 1'b1;
                        state     <= S_RREQ;
                    end
                end
                S_WDATA: begin
                    if (s_axi_wvalid) begin
                        err_q  <= err_q | wlast_bad;
                        addr_q <= next_addr;
                        cnt_q  <= cnt_q + 8'd1;
                        if (beat_last) state <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (s_axi_bready) state <= S_IDLE;
                end
                S_RREQ: begin
                    rfirst_q <= 1'b1;
                    state    <= S_RDATA;
                end
                S_RDATA: begin
                    // Register file data is only guaranteed for one cycle, so hold it across stalls.
                    if (rfirst_q) begin
                        rdata_q  <= rd_now;
                        rfirst_q <= 1'b0;
                    end
                    if (s_axi_rready) begin
                        if (beat_last) begin
                            state <= S_IDLE;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= next_addr;
                            state  <= S_RREQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign s_axi_awready = aw_grant;
    assign s_axi_arready = ar_grant;
    assign s_axi_wready  = (state == S_WDATA);
    assign s_axi_bvalid  = (state == S_WRESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = ((state == S_WRESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rvalid  = (state == S_RDATA);
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = rfirst_q ? rd_now : rdata_q;
    assign s_axi_rresp   = ((state == S_RDATA) && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast   = (state == S_RDATA) && beat_last;

    assign reg_addr  = addr_q;
    assign reg_wen   = (state == S_WDATA) && s_axi_wvalid && !err_q && !wlast_bad;
    assign reg_wdata = (state == S_WDATA) ? s_axi_wdata : '0;
    assign reg_wstrb = (state == S_WDATA) ? s_axi_wstrb : '0;
    assign reg_ren   = (state == S_RREQ) && !err_q;

    assign unused_inputs = ^{s_axi_awaddr[AXI_WIDTH_ADDR-1:REG_ADDR_BITS], s_axi_awaddr[1:0],
                             s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_araddr[AXI_WIDTH_ADDR-1:REG_ADDR_BITS], s_axi_araddr[1:0],
                             s_axi_arlock, s_axi_arcache, s_axi_arprot};

endmodule
